// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the skid-buffer pipeline register.
//   pipe_state_t : occupancy state of the two-entry buffer
//   WORD_W       : default datapath word width
package pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_BUSY  = 2'b01,
    S_FULL  = 2'b10
  } pipe_state_t;

  localparam int WORD_W = 16;

endpackage

// File: rtl/pipe_skid_reg_dff_en.sv
// dff_en: WIDTH-bit register with load enable and asynchronous active-high
// reset that clears the stored word to zero.
//   clk  : clock, loads on rising edge when en=1
//   rst  : asynchronous active-high clear
//   en   : load enable
//   d    : next word
//   q    : stored word
module dff_en #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready pipeline register (skid buffer).
// Replaces a bare stage flop, adding backpressure and flush at full
// one-word-per-cycle throughput. in_ready is decoded from registered state
// only, so no combinational path runs from out_ready to in_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous discard of all held words
//   in_valid/in_data    : upstream word, in_ready back to upstream
//   out_valid/out_data  : oldest held word, out_ready from downstream
//   count               : number of held words (0..2)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q;
  logic             main_en, skid_en;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = in_data;
    main_en = 1'b0;
    skid_en = 1'b0;
    count   = 2'd0;

    case (state_q)
      S_EMPTY: count = 2'd0;
      S_BUSY:  count = 2'd1;
      S_FULL:  count = 2'd2;
      default: count = 2'd0;
    endcase

    // Flush wins over any handshake; held words stay in the data flops
    // as stale values but are no longer valid.
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_BUSY;
            main_en = 1'b1;
          end
        end
        S_BUSY: begin
          if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (in_fire) begin
            // Downstream stalled: park the new word behind the head.
            state_d = S_FULL;
            skid_en = 1'b1;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d = S_BUSY;
            main_d  = skid_q;
            main_en = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  dff_en #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  dff_en #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule
